// File: rtl/spi_slave_regfile.sv
// SPI slave with an internal register file: serial cmd/addr/data frames,
// single or auto-increment burst writes and reads, sticky error flag.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | no frame; first cmd bit is captured when cs falls
// S_CMD    | shifting in the command field
// S_ADDR   | shifting in the address field
// S_WDATA  | shifting in write words, committing each full word
// S_RDATA  | shifting read words out on dout, reloading seamlessly
// S_IGNORE | unknown command; wait for cs to rise
module spi_slave_regfile #(
  parameter int CMD_W  = 8,
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter logic [CMD_W-1:0] CMD_WR = 'h55,
  parameter logic [CMD_W-1:0] CMD_RD = 'h56
) (
  input  logic              sclk_m,
  input  logic              reset,
  input  logic              cs,
  input  logic              din,
  output logic              dout,
  output logic              busy,
  output logic              wr_pulse,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              frame_done,
  output logic              err
);

  localparam int CNT_MAX = (CMD_W > ADDR_W) ? ((CMD_W > DATA_W) ? CMD_W : DATA_W)
                                            : ((ADDR_W > DATA_W) ? ADDR_W : DATA_W);
  localparam int CNT_W = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WDATA, S_RDATA, S_IGNORE
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CMD_W-2:0]    cmd_sr_q, cmd_sr_d;
  logic [ADDR_W-2:0]   addr_sr_q, addr_sr_d;
  logic [DATA_W-2:0]   wd_sr_q, wd_sr_d;
  logic [DATA_W-1:0]   rd_sr_q, rd_sr_d;
  logic [ADDR_W-1:0]   addr_ptr_q, addr_ptr_d;
  logic                is_rd_q, is_rd_d;
  logic                err_q, err_d;
  logic                wr_pulse_q, wr_pulse_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                frame_done_q, frame_done_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [DATA_W-1:0]   mem_d [DEPTH];

  // The shift registers hold one bit less than their field: the final bit
  // is taken straight from din on the edge that completes the field.
  logic [CMD_W-1:0]    cmd_full;
  logic [ADDR_W-1:0]   addr_full;
  logic [DATA_W-1:0]   word_full;
  logic [ADDR_W-1:0]   addr_next;
  logic [ADDR_W-1:0]   rd_addr;
  logic                rd_ok;
  logic                wr_ok;
  logic [DATA_W-1:0]   rd_word;

  assign cmd_full  = {cmd_sr_q, din};
  assign addr_full = {addr_sr_q, din};
  assign word_full = {wd_sr_q, din};
  assign addr_next = addr_ptr_q + ADDR_W'(1);

  // First read word comes from the address still arriving on din.
  assign rd_addr = (state_q == S_ADDR) ? addr_full : addr_next;
  assign rd_ok   = ({1'b0, rd_addr} < DEPTH_L);
  assign wr_ok   = ({1'b0, addr_ptr_q} < DEPTH_L);
  assign rd_word = rd_ok ? mem_q[rd_addr[IDX_W-1:0]] : '0;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_sr_d     = cmd_sr_q;
    addr_sr_d    = addr_sr_q;
    wd_sr_d      = wd_sr_q;
    rd_sr_d      = rd_sr_q;
    addr_ptr_d   = addr_ptr_q;
    is_rd_d      = is_rd_q;
    err_d        = err_q;
    wr_pulse_d   = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
    mem_d        = mem_q;

    if (state_q != S_IDLE && cs) begin
      state_d      = S_IDLE;
      cnt_d        = '0;
      frame_done_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!cs) begin
            state_d  = S_CMD;
            cnt_d    = CNT_W'(1);
            cmd_sr_d = cmd_full[CMD_W-2:0];
            err_d    = 1'b0;
          end
        end
        S_CMD: begin
          cmd_sr_d = cmd_full[CMD_W-2:0];
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(CMD_W-1)) begin
            cnt_d = '0;
            if (cmd_full == CMD_WR) begin
              state_d = S_ADDR;
              is_rd_d = 1'b0;
            end else if (cmd_full == CMD_RD) begin
              state_d = S_ADDR;
              is_rd_d = 1'b1;
            end else begin
              state_d = S_IGNORE;
              err_d   = 1'b1;
            end
          end
        end
        S_ADDR: begin
          addr_sr_d = addr_full[ADDR_W-2:0];
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(ADDR_W-1)) begin
            cnt_d      = '0;
            addr_ptr_d = addr_full;
            if (is_rd_q) begin
              state_d = S_RDATA;
              rd_sr_d = rd_word;
              if (!rd_ok) err_d = 1'b1;
            end else begin
              state_d = S_WDATA;
            end
          end
        end
        S_WDATA: begin
          wd_sr_d = word_full[DATA_W-2:0];
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W-1)) begin
            cnt_d      = '0;
            addr_ptr_d = addr_next;
            if (wr_ok) begin
              mem_d[addr_ptr_q[IDX_W-1:0]] = word_full;
              wr_pulse_d = 1'b1;
              wr_addr_d  = addr_ptr_q;
              wr_data_d  = word_full;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_RDATA: begin
          rd_sr_d = {rd_sr_q[DATA_W-2:0], 1'b0};
          cnt_d   = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_W-1)) begin
            cnt_d      = '0;
            addr_ptr_d = addr_next;
            rd_sr_d    = rd_word;
            if (!rd_ok) err_d = 1'b1;
          end
        end
        S_IGNORE: begin
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge sclk_m) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cmd_sr_q     <= '0;
      addr_sr_q    <= '0;
      wd_sr_q      <= '0;
      rd_sr_q      <= '0;
      addr_ptr_q   <= '0;
      is_rd_q      <= 1'b0;
      err_q        <= 1'b0;
      wr_pulse_q   <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
      mem_q        <= '{default: '0};
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_sr_q     <= cmd_sr_d;
      addr_sr_q    <= addr_sr_d;
      wd_sr_q      <= wd_sr_d;
      rd_sr_q      <= rd_sr_d;
      addr_ptr_q   <= addr_ptr_d;
      is_rd_q      <= is_rd_d;
      err_q        <= err_d;
      wr_pulse_q   <= wr_pulse_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
      mem_q        <= mem_d;
    end
  end

  assign dout       = (state_q == S_RDATA) & rd_sr_q[DATA_W-1];
  assign busy       = (state_q != S_IDLE);
  assign wr_pulse   = wr_pulse_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;

endmodule
